fetch_engine: RTL and testbench

Line-transfer responder on the cache fetch interface. Accepts one fetch command from the write controller, performs either a line writeback (cache line memory → external memory) or a line refill (external memory → cache line memory), one word at a time, and pulses `fetch_done` on completion. Sits between the write controller's fetch port, the cache data memory, and the external memory bus.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/fetch_engine.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_engine.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: fetch command codes, line-memory write
// priorities and the proc/acc status encodings used by the write controller.
package cache_pkg;

  // Fetch command encodings on the fetch port
  localparam logic [1:0] FETCH_WB  = 2'b00;
  localparam logic [1:0] FETCH_RF  = 2'b01;
  localparam logic [1:0] FETCH_NOP = 2'b11;

  // Line-memory write priority encodings
  localparam logic [1:0] WPRI_NORM = 2'b00;
  localparam logic [1:0] WPRI_FILL = 2'b01;

  // Processor-side request status seen by the write controller
  typedef enum logic [1:0] {
    PROC_IDLE = 2'b00,
    PROC_BUSY = 2'b01,
    PROC_HIT  = 2'b10,
    PROC_MISS = 2'b11
  } proc_status_t;

  // Access result status returned to the write controller
  typedef enum logic [1:0] {
    ACC_OK    = 2'b00,
    ACC_RETRY = 2'b01,
    ACC_ERR   = 2'b10,
    ACC_NONE  = 2'b11
  } acc_status_t;

  // True when a fetch command moves line data
  function automatic logic is_xfer_cmd(input logic [1:0] cmd);
    return (cmd == FETCH_WB) || (cmd == FETCH_RF);
  endfunction

endpackage

// File: rtl/fetch_engine.sv
// Line-transfer responder: executes one writeback or refill command a word
// at a time between the cache line memory and the external memory bus.
module fetch_engine
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          fetch_req,
  output logic                                          fetch_gnt,
  input  logic [1:0]                                    fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                 fetch_tag,
  input  logic [addr_width-1:0]                         fetch_addr,
  output logic                                          fetch_done,
  output logic                                          mem_ren,
  input  logic                                          mem_rready,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
  input  logic [data_width-1:0]                         mem_rdata,
  output logic                                          mem_wen,
  input  logic                                          mem_wready,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_waddr,
  output logic [data_width-1:0]                         mem_wdata,
  output logic [1:0]                                    mem_wpri,
  output logic                                          ext_req,
  input  logic                                          ext_gnt,
  output logic                                          ext_we,
  output logic [addr_width-1:0]                         ext_addr,
  output logic [data_width-1:0]                         ext_wdata,
  input  logic                                          ext_rvalid,
  input  logic [data_width-1:0]                         ext_rdata
);

  localparam int tag_w   = $clog2(list_depth);
  localparam int idx_w   = $clog2(list_width);
  localparam int byte_sh = $clog2(data_width / 8);
  localparam int off_w   = $clog2(list_width * data_width / 8);
  localparam logic [addr_width-1:0] off_mask =
    (addr_width'(1) << off_w) - addr_width'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_RD   = 3'd1,
    WB_CAP  = 3'd2,
    WB_WR   = 3'd3,
    RF_RD   = 3'd4,
    RF_WAIT = 3'd5,
    RF_WR   = 3'd6,
    DONE    = 3'd7
  } fetch_state_t;

  fetch_state_t          state_r;
  fetch_state_t          next_state_s;
  logic [1:0]            cmd_r;
  logic [tag_w-1:0]      tag_r;
  logic [addr_width-1:0] base_r;
  logic [idx_w-1:0]      cnt_r;
  logic [data_width-1:0] buf_r;

  logic                  accept_s;
  logic                  cnt_inc_s;
  logic                  ld_mem_s;
  logic                  ld_ext_s;
  logic                  last_word_s;
  logic [addr_width-1:0] word_addr_s;
  logic [tag_w+idx_w-1:0] line_addr_s;

  assign last_word_s = (cnt_r == idx_w'(list_width - 1));
  assign word_addr_s = base_r + (addr_width'(cnt_r) << byte_sh);
  assign line_addr_s = {tag_r, cnt_r};

  // State register; reset abandons any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; every output depends on state only
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    cnt_inc_s    = 1'b0;
    ld_mem_s     = 1'b0;
    ld_ext_s     = 1'b0;
    fetch_gnt    = 1'b0;
    fetch_done   = 1'b0;
    mem_ren      = 1'b0;
    mem_raddr    = '0;
    mem_wen      = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_wpri     = WPRI_NORM;
    ext_req      = 1'b0;
    ext_we       = 1'b0;
    ext_addr     = '0;
    ext_wdata    = '0;
    case (state_r)
      IDLE: begin
        fetch_gnt = 1'b1;
        if (fetch_req) begin
          accept_s = 1'b1;
          if (fetch_cmd == FETCH_WB) begin
            next_state_s = WB_RD;
          end else if (fetch_cmd == FETCH_RF) begin
            next_state_s = RF_RD;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WB_RD: begin
        mem_ren   = 1'b1;
        mem_raddr = line_addr_s;
        if (mem_rready) begin
          next_state_s = WB_CAP;
        end else begin
          next_state_s = WB_RD;
        end
      end
      WB_CAP: begin
        ld_mem_s     = 1'b1;
        next_state_s = WB_WR;
      end
      WB_WR: begin
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = word_addr_s;
        ext_wdata = buf_r;
        if (ext_gnt) begin
          if (last_word_s) begin
            next_state_s = DONE;
          end else begin
            cnt_inc_s    = 1'b1;
            next_state_s = WB_RD;
          end
        end else begin
          next_state_s = WB_WR;
        end
      end
      RF_RD: begin
        ext_req  = 1'b1;
        ext_addr = word_addr_s;
        if (ext_gnt) begin
          next_state_s = RF_WAIT;
        end else begin
          next_state_s = RF_RD;
        end
      end
      RF_WAIT: begin
        if (ext_rvalid) begin
          ld_ext_s     = 1'b1;
          next_state_s = RF_WR;
        end else begin
          next_state_s = RF_WAIT;
        end
      end
      RF_WR: begin
        mem_wen   = 1'b1;
        mem_waddr = line_addr_s;
        mem_wdata = buf_r;
        mem_wpri  = (cmd_r == FETCH_RF) ? WPRI_FILL : WPRI_NORM;
        if (mem_wready) begin
          if (last_word_s) begin
            next_state_s = DONE;
          end else begin
            cnt_inc_s    = 1'b1;
            next_state_s = RF_RD;
          end
        end else begin
          next_state_s = RF_WR;
        end
      end
      DONE: begin
        fetch_done   = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Command capture, word counter and the single word buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r  <= 2'b00;
      tag_r  <= '0;
      base_r <= '0;
      cnt_r  <= '0;
      buf_r  <= '0;
    end else begin
      if (accept_s) begin
        cmd_r  <= fetch_cmd;
        tag_r  <= fetch_tag;
        base_r <= fetch_addr & ~off_mask;
        cnt_r  <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + idx_w'(1);
      end
      if (ld_mem_s) begin
        buf_r <= mem_rdata;
      end else if (ld_ext_s) begin
        buf_r <= ext_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_engine.sv
// Scoreboard bench for fetch_engine: expected line/external traffic is
// queued at command accept and popped at each handshake.
module tb_fetch_engine;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        fetch_gnt;
  logic [1:0]  fetch_cmd;
  logic [1:0]  fetch_tag;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic        mem_ren;
  logic        mem_rready;
  logic [6:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic        mem_wready;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wpri;
  logic        ext_req;
  logic        ext_gnt;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ext_t;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  p;
  } mw_t;

  ext_t        exp_ext_q[$];
  logic [6:0]  exp_mr_q[$];
  mw_t         exp_mw_q[$];
  logic [31:0] lmem [0:127];

  fetch_engine dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd),
    .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .mem_ren(mem_ren), .mem_rready(mem_rready), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wpri(mem_wpri),
    .ext_req(ext_req), .ext_gnt(ext_gnt), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory contents: a value that encodes its own address
  function automatic logic [31:0] ext_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic clear_inputs();
    fetch_req  = 1'b0;
    fetch_cmd  = 2'b00;
    fetch_tag  = 2'd0;
    fetch_addr = 32'd0;
    mem_rready = 1'b0;
    mem_rdata  = 32'd0;
    mem_wready = 1'b0;
    ext_gnt    = 1'b0;
    ext_rvalid = 1'b0;
    ext_rdata  = 32'd0;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (fetch_gnt !== 1'b1 || fetch_done !== 1'b0 || mem_ren !== 1'b0 ||
        mem_wen !== 1'b0 || ext_req !== 1'b0 || ext_we !== 1'b0) begin
      bad++;
      $display("FAIL %s: gnt=%b done=%b ren=%b wen=%b req=%b we=%b, required gnt=1 others 0",
               name, fetch_gnt, fetch_done, mem_ren, mem_wen, ext_req, ext_we);
    end
    total++;
    if (ext_addr !== 32'd0 || ext_wdata !== 32'd0 || mem_raddr !== 7'd0 ||
        mem_waddr !== 7'd0 || mem_wdata !== 32'd0 || mem_wpri !== 2'b00) begin
      bad++;
      $display("FAIL %s_bus: ext_addr=%h ext_wdata=%h raddr=%h waddr=%h wdata=%h wpri=%b, required all 0",
               name, ext_addr, ext_wdata, mem_raddr, mem_waddr, mem_wdata, mem_wpri);
    end
  endtask

  // Run one command to completion, servicing all ports with optional stalls
  task automatic run_cmd(input logic [1:0] cmd, input logic [1:0] tag,
                         input logic [31:0] addr, input bit stall,
                         input int max_dly, input int exp_done,
                         input int abort_at, input bit spur);
    logic [31:0] base;
    int          cyc;
    int          dones;
    int          mw_cnt;
    bit          fin;
    bit          abort_now;
    bit          rv_pend;
    int          rv_dly;
    logic [31:0] rv_addr;
    bit          st_ext, st_mr, st_mw;
    logic [65:0] sv_ext;
    logic [7:0]  sv_mr;
    logic [41:0] sv_mw;
    ext_t        e;
    mw_t         m;
    logic [6:0]  ra;

    base = addr & 32'hFFFF_FF80;
    exp_ext_q.delete();
    exp_mr_q.delete();
    exp_mw_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (cmd == 2'b00) begin
        exp_mr_q.push_back({tag, 5'(i)});
        exp_ext_q.push_back('{we: 1'b1, addr: base + 32'(4 * i), data: lmem[{tag, 5'(i)}]});
      end else if (cmd == 2'b01) begin
        exp_ext_q.push_back('{we: 1'b0, addr: base + 32'(4 * i), data: 32'd0});
        exp_mw_q.push_back('{a: {tag, 5'(i)}, d: ext_word(base + 32'(4 * i)), p: 2'b01});
      end
    end

    @(negedge clk);
    total++;
    if (fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL gnt_before_cmd: got %b, required 1", fetch_gnt);
    end
    fetch_req  = 1'b1;
    fetch_cmd  = cmd;
    fetch_tag  = tag;
    fetch_addr = addr;

    cyc = 0; dones = 0; mw_cnt = 0; fin = 1'b0; abort_now = 1'b0;
    rv_pend = 1'b0; rv_dly = 0; rv_addr = 32'd0;
    st_ext = 1'b0; st_mr = 1'b0; st_mw = 1'b0;
    sv_ext = '0; sv_mr = '0; sv_mw = '0;

    while (!fin) begin
      @(negedge clk);
      cyc++;
      fetch_req = 1'b0;

      if (abort_now) begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_async");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          total++;
          if (fetch_done !== 1'b0 || mem_wen !== 1'b0 || ext_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: done=%b wen=%b req=%b, required 0 0 0",
                     fetch_done, mem_wen, ext_req);
          end
        end
        clear_inputs();
        rst_n = 1'b1;
        exp_ext_q.delete();
        exp_mr_q.delete();
        exp_mw_q.delete();
        fin = 1'b1;
      end else begin
        if (st_ext) begin
          total++;
          if ({ext_req, ext_we, ext_addr, ext_wdata} !== sv_ext) begin
            bad++;
            $display("FAIL ext_stable: got %h, required %h", {ext_req, ext_we, ext_addr, ext_wdata}, sv_ext);
          end
        end
        if (st_mr) begin
          total++;
          if ({mem_ren, mem_raddr} !== sv_mr) begin
            bad++;
            $display("FAIL mrd_stable: got %h, required %h", {mem_ren, mem_raddr}, sv_mr);
          end
        end
        if (st_mw) begin
          total++;
          if ({mem_wen, mem_waddr, mem_wdata, mem_wpri} !== sv_mw) begin
            bad++;
            $display("FAIL mwr_stable: got %h, required %h", {mem_wen, mem_waddr, mem_wdata, mem_wpri}, sv_mw);
          end
        end

        if (dones == 0) begin
          total++;
          if (fetch_gnt !== 1'b0) begin
            bad++;
            $display("FAIL gnt_busy: cycle %0d got 1, required 0", cyc);
          end
        end

        if (fetch_done === 1'b1) begin
          dones++;
          total++;
          if (dones != 1 || (exp_done >= 0 && cyc != exp_done)) begin
            bad++;
            $display("FAIL done_cycle: pulse %0d at cycle %0d, required one pulse at cycle %0d",
                     dones, cyc, exp_done);
          end
          total++;
          if (exp_ext_q.size() != 0 || exp_mr_q.size() != 0 || exp_mw_q.size() != 0) begin
            bad++;
            $display("FAIL done_early: pending ext=%0d mrd=%0d mwr=%0d, required 0 0 0",
                     exp_ext_q.size(), exp_mr_q.size(), exp_mw_q.size());
          end
        end else if (dones > 0) begin
          total++;
          if (fetch_gnt !== 1'b1) begin
            bad++;
            $display("FAIL gnt_after_done: got %b, required 1", fetch_gnt);
          end
          fin = 1'b1;
        end

        ext_gnt    = 1'b0;
        mem_rready = 1'b0;
        mem_wready = 1'b0;
        ext_rvalid = 1'b0;

        if (rv_pend) begin
          if (rv_dly == 0) begin
            ext_rvalid = 1'b1;
            ext_rdata  = ext_word(rv_addr);
            rv_pend    = 1'b0;
          end else begin
            rv_dly--;
          end
        end

        st_ext = 1'b0;
        if (ext_req === 1'b1) begin
          if (spur) begin
            ext_rvalid = 1'b1;
            ext_rdata  = 32'hDEAD_BEEF;
          end
          ext_gnt = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (ext_gnt) begin
            total++;
            if (exp_ext_q.size() == 0) begin
              bad++;
              $display("FAIL ext_unexpected: we=%b addr=%h, required no request", ext_we, ext_addr);
            end else begin
              e = exp_ext_q.pop_front();
              if (ext_we !== e.we || ext_addr !== e.addr || (e.we && ext_wdata !== e.data)) begin
                bad++;
                $display("FAIL ext_xfer: we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                         ext_we, ext_addr, ext_wdata, e.we, e.addr, e.data);
              end
            end
            if (ext_we === 1'b0) begin
              rv_pend = 1'b1;
              rv_dly  = (max_dly > 0) ? $urandom_range(0, max_dly) : 0;
              rv_addr = ext_addr;
            end
          end else begin
            st_ext = 1'b1;
            sv_ext = {ext_req, ext_we, ext_addr, ext_wdata};
          end
        end

        st_mr = 1'b0;
        if (mem_ren === 1'b1) begin
          mem_rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (mem_rready) begin
            ra = mem_raddr;
            mem_rdata = lmem[ra];
            total++;
            if (exp_mr_q.size() == 0) begin
              bad++;
              $display("FAIL mrd_unexpected: raddr=%h, required no read", mem_raddr);
            end else if (mem_raddr !== exp_mr_q[0]) begin
              bad++;
              $display("FAIL mrd_addr: got %h, required %h", mem_raddr, exp_mr_q[0]);
              void'(exp_mr_q.pop_front());
            end else begin
              void'(exp_mr_q.pop_front());
            end
          end else begin
            st_mr = 1'b1;
            sv_mr = {mem_ren, mem_raddr};
          end
        end

        st_mw = 1'b0;
        if (mem_wen === 1'b1) begin
          mem_wready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (mem_wready) begin
            total++;
            if (exp_mw_q.size() == 0) begin
              bad++;
              $display("FAIL mwr_unexpected: waddr=%h data=%h, required no write", mem_waddr, mem_wdata);
            end else begin
              m = exp_mw_q.pop_front();
              if (mem_waddr !== m.a || mem_wdata !== m.d || mem_wpri !== m.p) begin
                bad++;
                $display("FAIL mwr_xfer: addr=%h data=%h pri=%b, required addr=%h data=%h pri=%b",
                         mem_waddr, mem_wdata, mem_wpri, m.a, m.d, m.p);
              end
            end
            ra = mem_waddr;
            lmem[ra] = mem_wdata;
            mw_cnt++;
            if (abort_at > 0 && mw_cnt == abort_at) abort_now = 1'b1;
          end else begin
            st_mw = 1'b1;
            sv_mw = {mem_wen, mem_waddr, mem_wdata, mem_wpri};
          end
        end

        if (cyc > 3000) begin
          total++;
          bad++;
          $display("FAIL timeout: %0d cycles without completion, required fetch_done", cyc);
          fin = 1'b1;
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_idle_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_refill();
    run_cmd(2'b01, 2'd2, 32'h0000_1234, 1'b0, 0, 97, -1, 1'b0);
  endtask

  task automatic test_writeback();
    for (int i = 0; i < 32; i++) lmem[{2'd1, 5'(i)}] = 32'hA000 + 32'(i);
    run_cmd(2'b00, 2'd1, 32'h0000_8000, 1'b0, 0, 97, -1, 1'b0);
  endtask

  task automatic test_noop();
    run_cmd(2'b11, 2'd3, 32'h1234_5678, 1'b0, 0, 1, -1, 1'b0);
    run_cmd(2'b10, 2'd0, 32'h0000_0000, 1'b0, 0, 1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic exp_done_b;
    logic exp_gnt_b;
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_cmd = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_done_b = (c % 2) == 1;
      exp_gnt_b  = (c % 2) == 0;
      total++;
      if (fetch_done !== exp_done_b || fetch_gnt !== exp_gnt_b ||
          ext_req !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
        bad++;
        $display("FAIL b2b cycle %0d: done=%b gnt=%b traffic=%b%b%b, required done=%b gnt=%b traffic=000",
                 c, fetch_done, fetch_gnt, ext_req, mem_ren, mem_wen, exp_done_b, exp_gnt_b);
      end
    end
    fetch_req = 1'b0;
    @(negedge clk);
    check_idle_outputs("b2b_end");
  endtask

  task automatic test_backpressure();
    run_cmd(2'b01, 2'd3, 32'h4567_89AB, 1'b1, 5, -1, -1, 1'b0);
    run_cmd(2'b00, 2'd2, 32'h0000_F0F0, 1'b1, 0, -1, -1, 1'b0);
    run_cmd(2'b00, 2'd3, 32'h0001_0000, 1'b1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_cmd(2'b01, 2'd0, 32'h0000_2000, 1'b0, 0, -1, 6, 1'b0);
    run_cmd(2'b01, 2'd0, 32'h0000_2000, 1'b0, 0, 97, -1, 1'b0);
  endtask

  task automatic test_spurious();
    run_cmd(2'b01, 2'd1, 32'h0000_3300, 1'b1, 3, -1, -1, 1'b1);
    run_cmd(2'b00, 2'd1, 32'h0000_4400, 1'b1, 0, -1, -1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) lmem[i] = 32'h0;
    test_reset();
    test_refill();
    test_writeback();
    test_noop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
